digit_entry_buffer: RTL

//  Parametrised successor to the fixed 11-digit phone-number entry path.

---
 rtl/digit_entry_buffer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/digit_entry_buffer.sv
// Keypad digit-entry buffer: holds up to MAX_DIGITS typed digits with backspace/clear/enter,
// an EDIT/FULL/DONE state machine and a scrolling NUM_SEG-digit display window.
module digit_entry_buffer #(
  parameter int unsigned MAX_DIGITS = 11,
  parameter int unsigned NUM_SEG    = 4,
  parameter logic [4:0]  BLANK_CODE = 5'h1F,
  localparam int unsigned CNT_W     = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    page_next,
  input  logic                    page_prev,
  output logic [4*MAX_DIGITS-1:0] number,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    number_valid,
  output logic                    err,
  output logic [5*NUM_SEG-1:0]    disp_digits
);

  localparam int Md = int'(MAX_DIGITS);
  localparam logic [CNT_W:0] SegX = (CNT_W + 1)'(NUM_SEG);
  localparam logic [CNT_W:0] MaxX = (CNT_W + 1)'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] SegC = CNT_W'(NUM_SEG);

  typedef enum logic [1:0] {StEdit, StFull, StDone} state_e;

  state_e                  state_q, state_d;
  logic [4*MAX_DIGITS-1:0] number_q, number_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        win_base_q, win_base_d;
  logic                    err_q, err_d;
  logic                    full_q, full_d;
  logic                    valid_q, valid_d;
  logic [5*NUM_SEG-1:0]    disp_q, disp_d;

  logic key_digit, key_back, key_clear, key_enter;
  logic [CNT_W:0] cnt_dx;

  assign key_digit = key_code <= 4'h9;
  assign key_back  = key_code == 4'hA;
  assign key_clear = key_code == 4'hB;
  assign key_enter = key_code == 4'hC;
  assign cnt_dx    = {1'b0, count_d};

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEdit;
      number_q   <= '1;
      count_q    <= '0;
      win_base_q <= '0;
      err_q      <= 1'b0;
      full_q     <= 1'b0;
      valid_q    <= 1'b0;
      disp_q     <= {NUM_SEG{BLANK_CODE}};
    end else begin
      state_q    <= state_d;
      number_q   <= number_d;
      count_q    <= count_d;
      win_base_q <= win_base_d;
      err_q      <= err_d;
      full_q     <= full_d;
      valid_q    <= valid_d;
      disp_q     <= disp_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (key_valid) begin
      unique case (state_q)
        StEdit: if (key_digit && ({1'b0, count_q} + 1'b1) == MaxX) state_d = StFull;
        StFull: begin
          if (key_back || key_clear) state_d = StEdit;
          else if (key_enter)        state_d = StDone;
        end
        StDone: if (key_clear) state_d = StEdit;
        default: state_d = StEdit;
      endcase
    end
  end

  // Buffer, count, window base and error pulse
  always_comb begin
    number_d   = number_q;
    count_d    = count_q;
    win_base_d = win_base_q;
    err_d      = 1'b0;
    if (key_valid) begin
      unique case (state_q)
        StEdit: begin
          if (key_digit) begin
            number_d[4*(Md-1-int'(count_q)) +: 4] = key_code;
            count_d = count_q + 1'b1;
          end else if (key_back) begin
            if (count_q != '0) begin
              number_d[4*(Md-int'(count_q)) +: 4] = 4'hF;
              count_d = count_q - 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_clear) begin
            number_d = '1;
            count_d  = '0;
          end else if (key_enter) begin
            err_d = 1'b1;
          end
        end
        StFull: begin
          if (key_digit) begin
            err_d = 1'b1;
          end else if (key_back) begin
            number_d[4*(Md-int'(count_q)) +: 4] = 4'hF;
            count_d = count_q - 1'b1;
          end else if (key_clear) begin
            number_d = '1;
            count_d  = '0;
          end
        end
        StDone: begin
          if (key_clear) begin
            number_d = '1;
            count_d  = '0;
          end else if (key_code <= 4'hC) begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
      // Keep the newest digit in view whenever the length changes
      if (count_d != count_q) begin
        win_base_d = (cnt_dx > SegX) ? CNT_W'(cnt_dx - SegX) : '0;
      end
    end else if (page_next && !page_prev) begin
      if (({1'b0, win_base_q} + SegX) < {1'b0, count_q}) win_base_d = win_base_q + SegC;
    end else if (page_prev && !page_next) begin
      win_base_d = (win_base_q >= SegC) ? win_base_q - SegC : '0;
    end
  end

  // Output next values, computed from the next buffer state so they register together
  always_comb begin
    full_d  = cnt_dx == MaxX;
    valid_d = state_d == StDone;
    disp_d  = '0;
    for (int k = 0; k < int'(NUM_SEG); k++) begin
      logic [CNT_W:0] idx;
      idx = {1'b0, win_base_d} + (CNT_W + 1)'(k);
      if (idx < cnt_dx) begin
        disp_d[5*(int'(NUM_SEG)-1-k) +: 5] = {1'b0, number_d[4*(Md-1-int'(idx)) +: 4]};
      end else begin
        disp_d[5*(int'(NUM_SEG)-1-k) +: 5] = BLANK_CODE;
      end
    end
  end

  assign number       = number_q;
  assign count        = count_q;
  assign full         = full_q;
  assign number_valid = valid_q;
  assign err          = err_q;
  assign disp_digits  = disp_q;

endmodule
